vector_fir_mac: RTL and testbench
=================================

// Module: vector_fir_mac
// PURPOSE
//  Vector multiply-accumulate engine directly downstream of the vector register file.
//  Consumes rd1/rd2 operand pairs (16 x int8 samples, 16 x Q1.7 coefficients), one pair per beat.
//  Accumulates per lane over a programmable tap count, then rounds and saturates.
//  Writes the 128-bit result back through the register file write port (we3/ra3/wd3).
// PARAMETERS
//  LANES       16  lanes per vector
//  DATAWIDTH   8   signed lane width (samples and coefficients)
//  ACCWIDTH    24  signed per-lane accumulator width
//  SHIFT       7   coefficient fraction bits; right shift applied before saturation
//  TAPW        8   tap counter width (max 255 taps)
//  REGSIZEINT  4   register address width
// PORTS
//  clk        in   1                    clock, rising edge
//  rst        in   1                    synchronous, active-low reset
//  start      in   1                    begin operation; sampled only in IDLE
//  taps       in   TAPW                 beat count, latched on start
//  dst        in   REGSIZEINT           destination register, latched on start
//  vin_valid  in   1                    operand pair valid
//  vin_ready  out  1                    engine accepts operand pair
//  va         in   LANES*DATAWIDTH      samples; lane i = va[8i+7:8i]
//  vb         in   LANES*DATAWIDTH      coefficients; same packing as va
//  busy       out  1                    high in every state except IDLE
//  we         out  1                    register file write enable (to we3)
//  wa         out  REGSIZEINT           write address (to ra3)
//  wd         out  LANES*DATAWIDTH      write data (to wd3); lane 0 in bits [7:0]
// BEHAVIOUR
//  Reset (rst=0 at clk edge):
//   state=IDLE; vin_ready=0, busy=0, we=0, wa=0, wd=0.
//   Accumulators, product registers and counter are cleared.
//   Reset mid-operation aborts the operation; no write occurs.
//  FSM states: IDLE, ACCUM, DRAIN, ROUND, WRITE.
//   IDLE  -> start=1: latch taps and dst; clear accumulators.
//            Go to ACCUM if taps!=0, otherwise ROUND (writes a zero vector).
//   ACCUM -> vin_ready=1. Each beat (vin_valid & vin_ready):
//            prod[i] <= signed(va_i) * signed(vb_i); counter decrements.
//            Accepting the final beat moves to DRAIN.
//   DRAIN -> one cycle; the last registered product is added.
//   ROUND -> res_i = sat8((acc_i + 2**(SHIFT-1)) >>> SHIFT); range [-128,127].
//   WRITE -> we=1 for exactly one cycle, wa=dst, wd=res; next state IDLE.
//  Products pass through a one-stage register. Each product is added on the cycle after
//   its beat. Bubbles (vin_valid=0) add nothing.
//  Latency: final beat accepted at edge k -> we high during cycle k+3..k+4.
//  The accumulator never overflows: 255 * 16384 < 2**23. Arithmetic is full-precision signed.
//  start while busy=1 is ignored; this includes start in the WRITE cycle.
//  vin_valid outside ACCUM is ignored; va and vb need not be stable then.
//  wd and wa hold their last values after WRITE; only we deasserts.
// STRUCTURE
//  Package fir_pkg: state enum fir_state_t, LANES/DATAWIDTH/ACCWIDTH/SHIFT constants,
//   lane_t/acc_t typedefs, function sat_round(acc_t) -> lane_t.
//  Sub-module vector_mac_lane: one lane holding the product register, accumulator and
//   sat_round. It is instantiated LANES times via generate. The FSM and counter live in the top.
// TESTING
//  1) taps=1, va lanes=0x10, vb lanes=0x40 -> (1024+64)>>>7 = 8.
//     All wd lanes=0x08; we high exactly 1 cycle; wa=dst=5.
//  2) Saturation, taps=4:
//     va=0x7F, vb=0x7F -> all lanes 0x7F.
//     va=0x80, vb=0x7F -> all lanes 0x80.
//  3) Lane independence, taps=3: va lane i = i, vb lane i = 0x7F-i, vin_valid with random gaps.
//     wd matches the software model per lane; vin_ready=0 outside ACCUM.
//  4) taps=0 -> wd=0, we single pulse 2 cycles after start.
//     busy sequence 1,1 then 0.
//  5) rst=0 after 2 of 4 beats -> no we; busy=0 next cycle.
//     A new taps=1 op (0x10 * 0x40) then yields exactly 0x08 with no residue.
//  6) start pulsed during ACCUM and during WRITE -> ignored.
//     dst and taps keep their original values; exactly one write per accepted start.

Source files
------------

// File: rtl/vector_fir_mac_pkg.sv
// Shared types, constants and the round/saturate helper for the vector FIR MAC.
package fir_pkg;

  localparam int LANES      = 32'sd16;
  localparam int DATAWIDTH  = 32'sd8;
  localparam int ACCWIDTH   = 32'sd24;
  localparam int SHIFT      = 32'sd7;
  localparam int TAPW       = 32'sd8;
  localparam int REGSIZEINT = 32'sd4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    DRAIN = 3'd2,
    ROUND = 3'd3,
    WRITE = 3'd4
  } fir_state_t;

  typedef logic signed [DATAWIDTH-1:0]   lane_t;
  typedef logic signed [2*DATAWIDTH-1:0] prod_t;
  typedef logic signed [ACCWIDTH-1:0]    acc_t;

  localparam logic [TAPW-1:0] ONE_TAP = 8'd1;
  // Half an LSB of the result, i.e. 2**(SHIFT-1), for round-half-up.
  localparam acc_t RND_HALF = 24'sd64;
  localparam acc_t SAT_MAX  = 24'sd127;
  localparam acc_t SAT_MIN  = -24'sd128;

  // Round (add half, arithmetic shift) then clamp to the signed lane range.
  function automatic lane_t sat_round(input acc_t acc);
    acc_t  sum_s;
    acc_t  shr_s;
    lane_t res_s;
    sum_s = acc + RND_HALF;
    shr_s = sum_s >>> SHIFT;
    if (shr_s > SAT_MAX) begin
      res_s = 8'sh7F;
    end else if (shr_s < SAT_MIN) begin
      res_s = 8'sh80;
    end else begin
      res_s = shr_s[DATAWIDTH-1:0];
    end
    return res_s;
  endfunction

endpackage

// File: rtl/vector_fir_mac_if.sv
// Operand stream from the register file read ports: valid/ready plus the two vectors.
interface vector_fir_mac_if;
  import fir_pkg::*;

  logic                       vin_valid;
  logic                       vin_ready;
  logic [LANES*DATAWIDTH-1:0] va;
  logic [LANES*DATAWIDTH-1:0] vb;

  modport master (output vin_valid, output va, output vb, input vin_ready);
  modport slave  (input vin_valid, input va, input vb, output vin_ready);

endinterface

// File: rtl/vector_fir_mac_lane.sv
// One MAC lane: registered product, accumulator and rounded/saturated result.
module vector_mac_lane
  import fir_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  logic  beat,
  input  logic  round,
  input  lane_t a,
  input  lane_t b,
  output lane_t res
);

  prod_t prod_r;
  logic  pv_r;
  acc_t  acc_r;
  lane_t res_r;

  // Product stage feeds the accumulator one cycle later; round captures the final sum.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prod_r <= '0;
      pv_r   <= 1'b0;
      acc_r  <= '0;
      res_r  <= '0;
    end else if (clr) begin
      prod_r <= '0;
      pv_r   <= 1'b0;
      acc_r  <= '0;
    end else begin
      if (beat) begin
        prod_r <= a * b;
      end
      pv_r <= beat;
      // Only a product registered by a real beat is added; bubbles add nothing.
      if (pv_r) begin
        acc_r <= acc_r + {{(ACCWIDTH-2*DATAWIDTH){prod_r[2*DATAWIDTH-1]}}, prod_r};
      end
      if (round) begin
        res_r <= sat_round(acc_r);
      end
    end
  end

  assign res = res_r;

endmodule

// File: rtl/vector_fir_mac.sv
// Vector multiply-accumulate engine: control FSM, tap counter and write-back port.
module vector_fir_mac
  import fir_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [TAPW-1:0]            taps,
  input  logic [REGSIZEINT-1:0]      dst,
  vector_fir_mac_if.slave            vif,
  output logic                       busy,
  output logic                       we,
  output logic [REGSIZEINT-1:0]      wa,
  output logic [LANES*DATAWIDTH-1:0] wd
);

  fir_state_t                 state_r;
  fir_state_t                 state_s;
  logic [TAPW-1:0]            cnt_r;
  logic [REGSIZEINT-1:0]      dst_r;
  logic                       busy_r;
  logic                       ready_r;
  logic                       we_r;
  logic [REGSIZEINT-1:0]      wa_r;
  logic [LANES*DATAWIDTH-1:0] wd_r;
  logic                       start_ok_s;
  logic                       beat_s;
  logic                       round_s;
  logic                       write_s;
  logic [LANES*DATAWIDTH-1:0] res_all_s;

  // Next-state and per-cycle lane controls decoded from the current state.
  always_comb begin
    state_s    = state_r;
    start_ok_s = 1'b0;
    beat_s     = 1'b0;
    round_s    = 1'b0;
    write_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          start_ok_s = 1'b1;
          if (taps != {TAPW{1'b0}}) begin
            state_s = ACCUM;
          end else begin
            state_s = ROUND;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACCUM: begin
        if (vif.vin_valid && ready_r) begin
          beat_s = 1'b1;
          if (cnt_r == ONE_TAP) begin
            state_s = DRAIN;
          end else begin
            state_s = ACCUM;
          end
        end else begin
          state_s = ACCUM;
        end
      end
      DRAIN: state_s = ROUND;
      ROUND: begin
        round_s = 1'b1;
        state_s = WRITE;
      end
      WRITE: begin
        write_s = 1'b1;
        state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, tap counter, latched destination and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      dst_r   <= '0;
      busy_r  <= 1'b0;
      ready_r <= 1'b0;
      we_r    <= 1'b0;
      wa_r    <= '0;
      wd_r    <= '0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
      ready_r <= (state_s == ACCUM);
      we_r    <= write_s;
      if (start_ok_s) begin
        cnt_r <= taps;
        dst_r <= dst;
      end else if (beat_s) begin
        cnt_r <= cnt_r - ONE_TAP;
      end
      // wa/wd only change on a write, so they hold after we drops.
      if (write_s) begin
        wa_r <= dst_r;
        wd_r <= res_all_s;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    vector_mac_lane u_lane (
      .clk   (clk),
      .rst   (rst),
      .clr   (start_ok_s),
      .beat  (beat_s),
      .round (round_s),
      .a     (vif.va[i*DATAWIDTH +: DATAWIDTH]),
      .b     (vif.vb[i*DATAWIDTH +: DATAWIDTH]),
      .res   (res_all_s[i*DATAWIDTH +: DATAWIDTH])
    );
  end

  assign vif.vin_ready = ready_r;
  assign busy          = busy_r;
  assign we            = we_r;
  assign wa            = wa_r;
  assign wd            = wd_r;

endmodule

// File: tb/tb_vector_fir_mac.sv
// Self-checking bench for vector_fir_mac: table vectors, corner sequences, random ops.
module tb_vector_fir_mac;
  import fir_pkg::*;

  typedef struct {
    int         taps;
    logic [3:0] dst;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_lane;
  } vec_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [7:0]   taps;
  logic [3:0]   dst;
  logic         busy;
  logic         we;
  logic [3:0]   wa;
  logic [127:0] wd;

  logic [127:0] op_va [0:255];
  logic [127:0] op_vb [0:255];

  int tests;
  int fails;

  vector_fir_mac_if vif ();

  vector_fir_mac dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .taps  (taps),
    .dst   (dst),
    .vif   (vif),
    .busy  (busy),
    .we    (we),
    .wa    (wa),
    .wd    (wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: per-lane dot product over n beats, round half up, floor divide, clamp.
  function automatic logic [127:0] model(input int n);
    logic [127:0] r;
    longint s;
    longint q;
    int x;
    int y;
    r = '0;
    for (int l = 0; l < 16; l++) begin
      s = 0;
      for (int k = 0; k < n; k++) begin
        x = $signed(op_va[k][8*l +: 8]);
        y = $signed(op_vb[k][8*l +: 8]);
        s += x * y;
      end
      s += 64;
      q = (s >= 0) ? s / 128 : -((-s + 127) / 128);
      if (q > 127) q = 127;
      if (q < -128) q = -128;
      r[8*l +: 8] = q[7:0];
    end
    return r;
  endfunction

  // Runs one operation from the op arrays; optionally inserts gaps and stray starts.
  task automatic run_op(input int n_taps, input logic [3:0] d, input bit gaps,
                        input bit poke, output logic [127:0] got_wd);
    logic [127:0] exp_wd;
    int n;
    int guard;
    int lat;
    bit v;
    exp_wd = model(n_taps);
    start = 1'b1;
    taps  = n_taps[7:0];
    dst   = d;
    @(negedge clk);
    start = 1'b0;
    taps  = 8'($urandom);
    dst   = 4'($urandom);
    n = 0;
    guard = 0;
    while (n < n_taps && guard < 4000) begin
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      vif.vin_valid = v;
      vif.va = v ? op_va[n] : {$urandom, $urandom, $urandom, $urandom};
      vif.vb = v ? op_vb[n] : {$urandom, $urandom, $urandom, $urandom};
      start = poke && (n == 1);
      if (v && vif.vin_ready) n++;
      @(negedge clk);
      guard++;
    end
    vif.vin_valid = 1'b0;
    start = 1'b0;
    if (guard >= 4000) check("beat_timeout", 128'(n), 128'(n_taps));
    lat = 1;
    while (we !== 1'b1 && lat < 12) begin
      check("busy_high", busy, 1'b1);
      check("ready_low", vif.vin_ready, 1'b0);
      vif.vin_valid = 1'b1;
      start = poke && (lat == 3);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    vif.vin_valid = 1'b0;
    check("we_seen", we, 1'b1);
    check("latency", 128'(lat), (n_taps == 0) ? 128'd3 : 128'd4);
    check("wd", wd, exp_wd);
    check("wa", wa, d);
    check("busy_at_we", busy, 1'b0);
    got_wd = wd;
    repeat (3) begin
      @(negedge clk);
      check("we_single", we, 1'b0);
      check("wd_hold", wd, got_wd);
      check("wa_hold", wa, d);
      check("idle", busy, 1'b0);
    end
  endtask

  vec_t tbl [12];
  logic [127:0] got;
  bit seen;

  initial begin
    tests = 0;
    fails = 0;
    tbl[0]  = '{1,   4'd5,  8'h10, 8'h40, 8'h08};
    tbl[1]  = '{4,   4'd3,  8'h7F, 8'h7F, 8'h7F};
    tbl[2]  = '{4,   4'd9,  8'h80, 8'h7F, 8'h80};
    tbl[3]  = '{0,   4'd7,  8'h55, 8'h66, 8'h00};
    tbl[4]  = '{2,   4'd1,  8'hFF, 8'h01, 8'h00};
    tbl[5]  = '{3,   4'd15, 8'h80, 8'h80, 8'h7F};
    tbl[6]  = '{5,   4'd2,  8'hF0, 8'h10, 8'hF6};
    tbl[7]  = '{1,   4'd0,  8'h01, 8'h40, 8'h01};
    tbl[8]  = '{1,   4'd12, 8'h01, 8'h3F, 8'h00};
    tbl[9]  = '{1,   4'd6,  8'hFF, 8'h41, 8'hFF};
    tbl[10] = '{255, 4'd14, 8'h80, 8'h80, 8'h7F};
    tbl[11] = '{255, 4'd8,  8'h80, 8'h7F, 8'h80};

    rst = 1'b0;
    start = 1'b0;
    taps = 8'd0;
    dst = 4'd0;
    vif.vin_valid = 1'b0;
    vif.va = '0;
    vif.vb = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_we", we, 1'b0);
    check("rst_wa", wa, 4'd0);
    check("rst_wd", wd, 128'd0);
    check("rst_ready", vif.vin_ready, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    // Uniform-lane table vectors, odd entries with random bubbles.
    for (int t = 0; t < 12; t++) begin
      for (int k = 0; k < tbl[t].taps; k++) begin
        op_va[k] = {16{tbl[t].a}};
        op_vb[k] = {16{tbl[t].b}};
      end
      run_op(tbl[t].taps, tbl[t].dst, t[0], 1'b0, got);
      check("table_wd", got, {16{tbl[t].exp_lane}});
    end

    // Lane independence with gaps.
    for (int k = 0; k < 3; k++) begin
      for (int l = 0; l < 16; l++) begin
        op_va[k][8*l +: 8] = 8'(l);
        op_vb[k][8*l +: 8] = 8'(127 - l);
      end
    end
    run_op(3, 4'd10, 1'b1, 1'b0, got);

    // Reset after 2 of 4 beats aborts the operation.
    for (int k = 0; k < 4; k++) begin
      op_va[k] = {$urandom, $urandom, $urandom, $urandom};
      op_vb[k] = {$urandom, $urandom, $urandom, $urandom};
    end
    start = 1'b1;
    taps = 8'd4;
    dst = 4'd2;
    @(negedge clk);
    start = 1'b0;
    vif.vin_valid = 1'b1;
    vif.va = op_va[0];
    vif.vb = op_vb[0];
    @(negedge clk);
    vif.va = op_va[1];
    vif.vb = op_vb[1];
    @(negedge clk);
    vif.vin_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_ready", vif.vin_ready, 1'b0);
    check("abort_we", we, 1'b0);
    check("abort_wd", wd, 128'd0);
    check("abort_wa", wa, 4'd0);
    rst = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (we) seen = 1'b1;
    end
    check("abort_no_write", seen, 1'b0);
    op_va[0] = {16{8'h10}};
    op_vb[0] = {16{8'h40}};
    run_op(1, 4'd5, 1'b0, 1'b0, got);
    check("no_residue", got, {16{8'h08}});

    // Stray starts during ACCUM and during WRITE are ignored.
    op_va[0] = {16{8'h20}};
    op_vb[0] = {16{8'h30}};
    op_va[1] = {16{8'h20}};
    op_vb[1] = {16{8'h30}};
    run_op(2, 4'd6, 1'b0, 1'b1, got);
    check("poke_wd", got, {16{8'h18}});
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (we || busy) seen = 1'b1;
    end
    check("poke_no_extra", seen, 1'b0);

    // Random operations against the reference model.
    for (int r = 0; r < 10; r++) begin
      int nt;
      nt = $urandom_range(1, 12);
      for (int k = 0; k < nt; k++) begin
        op_va[k] = {$urandom, $urandom, $urandom, $urandom};
        op_vb[k] = {$urandom, $urandom, $urandom, $urandom};
      end
      run_op(nt, 4'($urandom), 1'b1, r[0], got);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
